io_mode_router: RTL
===================

// Module: io_mode_router
// PURPOSE
//  Parametrised, registered successor to the plain ui_in->uo_out passthrough.
//  Routes the dedicated input bus to the dedicated outputs through one of four run-time modes:
//   - registered pass
//   - DEPTH-stage delay line
//   - strobe-triggered sample/hold
//   - rising-edge event counter
//  Sits directly under the tt_um top; mode/strobe come in on uio_in, status goes out on uio_out.
// PARAMETERS
//  WIDTH  8  data width of ui_in/uo_out path, 1..8 (unused uo_out bits driven 0 by top)
//  DEPTH  4  delay-line length in mode 1, >=1; fill counter width $clog2(DEPTH+1)
// PORTS
//  clk      in   1      clock, all state on rising edge
//  rst_n    in   1      asynchronous active-low reset
//  ena      in   1      1 = advance state; 0 = freeze all registers (outputs hold)
//  ui_in    in   WIDTH  data input
//  uio_in   in   8      [1:0] mode select, [2] strobe, [7:3] ignored
//  uo_out   out  WIDTH  data output (registered)
//  uio_out  out  8      [7] valid, [6:5] mode_q, [4] parity (see CONFIGURATION), [3:0] 0
//  uio_oe   out  8      constant 8'hF8 ([7:3] outputs, [2:0] inputs), also during reset
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - all registers to 0: mode_q, out_q, delay line, fill, counter, valid_q, edge-detect prev regs
//    - uo_out=0, uio_out=0 immediately
//    - reset mid-operation discards all state; no reset-release glitch on uio_oe
//  - ena=0: no register changes at all (including mode_q and edge prevs)
//  - Mode sampling:
//    - mode_q <= uio_in[1:0] every ena cycle
//    - mode_chg = ena & (uio_in[1:0] != mode_q)
//    - on a mode_chg edge: out_q, delay line, fill, counter, valid_q <= 0; that cycle's ui_in is discarded
//    - new mode operates from the following edge
//  - Edge detectors:
//    - str_prev <= uio_in[2] and d0_prev <= ui_in[0] every ena cycle, in all modes
//    - prevs are never cleared by mode_chg, so a level already high at a mode switch is not an edge
//  - Mode 0 REG:
//    - out_q <= ui_in each ena edge; latency 1 cycle
//    - valid_q <= 1 on first ena edge after reset/mode_chg
//  - Mode 1 DELAY:
//    - sr[0] <= ui_in; sr[i] <= sr[i-1]; uo_out = sr[DEPTH-1]
//    - value sampled at edge N appears on uo_out after edge N+DEPTH-1 (DEPTH-cycle latency)
//    - fill increments per ena edge, saturates at DEPTH; valid = (fill==DEPTH)
//    - zeros shift out before valid
//  - Mode 2 SAMPLE:
//    - on ena edge with uio_in[2]=1 & str_prev=0: out_q <= ui_in, valid_q <= 1; latency 1
//    - strobe held high re-captures nothing; otherwise out_q holds
//  - Mode 3 COUNT:
//    - on ena edge with ui_in[0]=1 & d0_prev=0: cnt <= cnt+1, wraps 2^WIDTH-1 -> 0 silently
//    - uo_out = cnt; valid_q <= 1 on first ena edge after reset/mode_chg
//  - Simultaneous mode_chg with strobe/data edge: mode_chg wins (clear); the edge is lost
//  - uio_out[6:5] = mode_q, uio_out[7] = valid (mode 1: fill==DEPTH, else valid_q)
// CONFIGURATION
//  IO_PARITY_EN:
//    - defined: uio_out[4] = ^uo_out (1 when odd number of ones), combinational from registered uo_out
//    - undefined: uio_out[4] = 0 and no parity logic
//  uio_oe is 8'hF8 either way.
// TESTING
//  1. rst_n=0 mid-stream in mode 1 -> same cycle uo_out=0, uio_out=0, uio_oe=F8; after release valid=0.
//  2. Mode 0, ui_in=0xA5 -> uo_out=0xA5 and uio_out[7]=1 after one edge.
//  3. Mode 1, DEPTH=4, ui_in ramp 1,2,3..:
//     - uo_out=0 and valid=0 for 3 edges; 0x01 and valid=1 after 4th edge
//     - ena=0 for 2 cycles -> uo_out frozen
//  4. Mode 2:
//     - ui_in=0x3C with 1-cycle strobe -> uo_out=0x3C
//     - ui_in=0xFF with strobe held high -> uo_out stays 0x3C
//  5. Mode 3, WIDTH=8:
//     - 257 rising edges on ui_in[0] -> uo_out=0x01
//     - switch to mode 0 -> next edge uo_out=0, valid=0, uio_out[6:5]=00
//  6. IO_PARITY_EN defined, mode 0, ui_in=0x07 -> uio_out[4]=1; ui_in=0x03 -> 0; undefined -> always 0.

Source files
------------

// File: rtl/io_mode_router.sv
// Four-mode registered router from ui_in to uo_out: pass, delay line, strobe sample/hold, edge counter.
// Optional parity status bit on uio_out[4] is built only when IO_PARITY_EN is defined.
module io_mode_router #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] ui_in,
  input  logic [7:0]       uio_in,
  output logic [WIDTH-1:0] uo_out,
  output logic [7:0]       uio_out,
  output logic [7:0]       uio_oe
);

  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);

  localparam logic [1:0] MODE_REG    = 2'd0;
  localparam logic [1:0] MODE_DELAY  = 2'd1;
  localparam logic [1:0] MODE_SAMPLE = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] sr_q [DEPTH];
  logic [WIDTH-1:0] sr_d [DEPTH];
  logic [FW-1:0]    fill_q, fill_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             str_prev_q, str_prev_d;
  logic             d0_prev_q, d0_prev_d;

  logic mode_chg;
  logic str_rise;
  logic d0_rise;
  logic valid;
  logic parity;

  assign mode_chg = ena & (uio_in[1:0] != mode_q);
  assign str_rise = uio_in[2] & ~str_prev_q;
  assign d0_rise  = ui_in[0] & ~d0_prev_q;

  always_comb begin
    mode_d     = mode_q;
    out_d      = out_q;
    sr_d       = sr_q;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    str_prev_d = str_prev_q;
    d0_prev_d  = d0_prev_q;
    if (ena) begin
      mode_d     = uio_in[1:0];
      str_prev_d = uio_in[2];
      d0_prev_d  = ui_in[0];
      // A mode switch wipes the datapath and swallows this cycle's input and edges.
      if (mode_chg) begin
        out_d   = '0;
        fill_d  = '0;
        cnt_d   = '0;
        valid_d = 1'b0;
        for (int i = 0; i < DEPTH; i++) sr_d[i] = '0;
      end else begin
        case (mode_q)
          MODE_REG: begin
            out_d   = ui_in;
            valid_d = 1'b1;
          end
          MODE_DELAY: begin
            sr_d[0] = ui_in;
            for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
            if (fill_q != DEPTH_F) fill_d = fill_q + FW'(1);
          end
          MODE_SAMPLE: begin
            if (str_rise) begin
              out_d   = ui_in;
              valid_d = 1'b1;
            end
          end
          default: begin
            valid_d = 1'b1;
            if (d0_rise) cnt_d = cnt_q + WIDTH'(1);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= '0;
      out_q      <= '0;
      fill_q     <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      str_prev_q <= 1'b0;
      d0_prev_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      mode_q     <= mode_d;
      out_q      <= out_d;
      fill_q     <= fill_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      str_prev_q <= str_prev_d;
      d0_prev_q  <= d0_prev_d;
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= sr_d[i];
    end
  end

  always_comb begin
    case (mode_q)
      MODE_DELAY: uo_out = sr_q[DEPTH-1];
      MODE_COUNT: uo_out = cnt_q;
      default:    uo_out = out_q;
    endcase
  end

  assign valid = (mode_q == MODE_DELAY) ? (fill_q == DEPTH_F) : valid_q;

`ifdef IO_PARITY_EN
  assign parity = ^uo_out;
`else
  assign parity = 1'b0;
`endif

  assign uio_out = {valid, mode_q, parity, 4'b0000};
  assign uio_oe  = 8'hF8;

endmodule
